// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_state_t        - fetch FSM state encoding
//   PC_STEP              - byte distance between sequential instructions
//   BUBBLE_INSTR_DEFAULT - default instruction emitted for a bubble
//   ALIGN_MASK           - clears the byte-offset bits of an address
package if_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP              = 32'd4;
  localparam logic [31:0] BUBBLE_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK           = ~32'h3;

endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: request/ready handshake between the fetch unit and
// instruction memory.
//   imem_req   - fetch request (driven by the fetch unit)
//   imem_addr  - word-aligned fetch address (driven by the fetch unit)
//   imem_ready - memory completes the current request this cycle
//   imem_rdata - instruction data, valid with imem_ready
// Modports: master = fetch unit side, slave = memory side.
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_skid_buffer.sv
// if_skid_buffer: one-entry {pc, instr} buffer that catches a fetch which
// completes while the pipeline is frozen.
//   clk, rst        - clock, asynchronous active-high reset
//   load            - capture pc_in/instr_in and mark full
//   unload          - entry consumed, mark empty
//   invalidate      - entry flushed by a redirect, mark empty
//   pc_in, instr_in - entry to capture
//   full            - entry holds a completed fetch
//   pc, instr       - stored entry
module if_skid_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        invalidate,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        full,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      pc    <= 32'h0;
      instr <= 32'h0;
    end else if (invalidate || unload) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end. Owns the PC, fetches from a
// variable-latency memory, presents {PC+4, instr} to the IF pipeline
// register, holds under freeze (one completed fetch buffered) and redirects
// on a taken branch while letting an outstanding stale request drain.
//   clk, rst     - clock, asynchronous active-high reset
//   freeze       - hazard stall: hold outputs, issue no new fetch
//   branch_taken - redirect request, overrides freeze
//   branch_addr  - redirect target (low two bits ignored)
//   imem         - instruction memory handshake (master side)
//   pc_out       - address of presented instruction + 4
//   instr_out    - presented instruction
//   fetch_valid  - 1 = real fetch presented, 0 = bubble
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = BUBBLE_INSTR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_addr,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            pc_out,
  output logic [31:0]            instr_out,
  output logic                   fetch_valid
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  stale_addr, stale_addr_nxt;
  logic [31:0]  pc_out_nxt, instr_out_nxt;
  logic         fetch_valid_nxt;
  logic [31:0]  pc_inc, target;
  logic         skid_load, skid_unload, skid_inv, skid_full;
  logic [31:0]  skid_pc, skid_instr;

  assign pc_inc = pc + PC_STEP;
  assign target = branch_addr & ALIGN_MASK;

  // Request side is decoded purely from registered state.
  assign imem.imem_req  = (state == FETCH) || (state == DISCARD);
  assign imem.imem_addr = (state == DISCARD) ? stale_addr : pc;

  if_skid_buffer u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .unload     (skid_unload),
    .invalidate (skid_inv),
    .pc_in      (pc_inc),
    .instr_in   (imem.imem_rdata),
    .full       (skid_full),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    stale_addr_nxt  = stale_addr;
    pc_out_nxt      = pc_out;
    instr_out_nxt   = instr_out;
    fetch_valid_nxt = fetch_valid;
    skid_load       = 1'b0;
    skid_unload     = 1'b0;
    skid_inv        = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (branch_taken) begin
          pc_nxt          = target;
          instr_out_nxt   = BUBBLE_INSTR;
          fetch_valid_nxt = 1'b0;
          // An unfinished request must still complete at its old address.
          if (!imem.imem_ready) begin
            stale_addr_nxt = pc;
            state_nxt      = DISCARD;
          end
        end else if (freeze) begin
          if (imem.imem_ready) begin
            skid_load = 1'b1;
            pc_nxt    = pc_inc;
            state_nxt = HOLD;
          end
        end else if (imem.imem_ready) begin
          pc_out_nxt      = pc_inc;
          instr_out_nxt   = imem.imem_rdata;
          fetch_valid_nxt = 1'b1;
          pc_nxt          = pc_inc;
        end else begin
          instr_out_nxt   = BUBBLE_INSTR;
          fetch_valid_nxt = 1'b0;
        end
      end
      DISCARD: begin
        instr_out_nxt   = BUBBLE_INSTR;
        fetch_valid_nxt = 1'b0;
        if (branch_taken) pc_nxt = target;
        if (imem.imem_ready) state_nxt = FETCH;
      end
      HOLD: begin
        if (branch_taken) begin
          skid_inv        = 1'b1;
          pc_nxt          = target;
          instr_out_nxt   = BUBBLE_INSTR;
          fetch_valid_nxt = 1'b0;
          state_nxt       = FETCH;
        end else if (!freeze) begin
          if (skid_full) begin
            pc_out_nxt      = skid_pc;
            instr_out_nxt   = skid_instr;
            fetch_valid_nxt = 1'b1;
          end
          skid_unload = 1'b1;
          state_nxt   = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      stale_addr  <= RESET_PC;
      pc_out      <= 32'h0;
      instr_out   <= BUBBLE_INSTR;
      fetch_valid <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      stale_addr  <= stale_addr_nxt;
      pc_out      <= pc_out_nxt;
      instr_out   <= instr_out_nxt;
      fetch_valid <= fetch_valid_nxt;
    end
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end that produces the PC+4 / instruction pair consumed by the IF-stage pipeline register. It owns the program counter and runs a request/ready handshake to a variable-latency instruction memory. It holds its registered outputs under hazard freeze, buffering at most one completed fetch, and redirects on a taken branch. A request already outstanding at redirect time is allowed to complete, and its data is discarded.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- BUBBLE_INSTR, 32'h0000_0000: instruction emitted when no valid fetch is presented.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- freeze  in  1  hazard stall from the hazard unit; hold outputs, issue no new fetch.
- branch_taken  in  1  redirect request from EX; overrides freeze.
- branch_addr  in  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory completes the current request this cycle.
- imem_rdata  in  32  instruction data, valid when imem_ready=1.
- pc_out  out  32  registered address of presented instruction + 4.
- instr_out  out  32  registered presented instruction.
- fetch_valid  out  1  registered; 1 = pc_out/instr_out carry a real fetch, 0 = bubble.

## Operation
- State machine states and their imem_req value:
  - IDLE: imem_req=0.
  - FETCH: imem_req=1, imem_addr=PC.
  - DISCARD: imem_req=1, imem_addr=stale address.
  - HOLD: imem_req=0; the one-entry skid buffer is full.
- Handshake rules:
  - A request completes at a rising edge with imem_req=1 and imem_ready=1.
  - A request is never withdrawn or re-addressed before it completes.
  - imem_ready while imem_req=0 is ignored.
- Transitions (branch_taken has top priority; freeze second):
  - IDLE → FETCH on the first edge after reset release.
  - FETCH, branch_taken:
    - PC ← branch_addr & ~3; outputs ← bubble.
    - If imem_ready: data dropped, stay FETCH. Otherwise → DISCARD with the stale address latched.
  - FETCH, freeze=0, imem_ready: pc_out ← PC+4, instr_out ← imem_rdata, fetch_valid ← 1, PC ← PC+4.
  - FETCH, freeze=0, no imem_ready: outputs ← bubble (pc_out holds, instr_out ← BUBBLE_INSTR, fetch_valid ← 0).
  - FETCH, freeze=1, imem_ready: skid ← {PC+4, imem_rdata}, PC ← PC+4, → HOLD; outputs hold.
  - FETCH, freeze=1, no imem_ready: outputs hold; the request stays asserted.
  - DISCARD, imem_ready: data dropped, → FETCH at the redirected PC; outputs remain bubble.
  - DISCARD, branch_taken again: PC retargeted; stay DISCARD.
  - HOLD, branch_taken: skid invalidated, PC ← target, outputs ← bubble, → FETCH.
  - HOLD, freeze=0: outputs ← skid, fetch_valid ← 1, → FETCH.
  - HOLD, freeze=1: all state holds.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values:
  - state=IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - pc_out=0, instr_out=BUBBLE_INSTR, fetch_valid=0, skid empty.
- Latency:
  - Registered outputs update at the same edge the memory completes, i.e. visible the cycle after imem_ready.
  - Zero-wait memory (imem_ready tied 1) sustains one instruction per cycle.
- Redirect cost: first target instruction presented ≥1 cycle after branch_taken, plus the remaining latency of the stale request when in DISCARD.
- Reset mid-operation: asynchronous; imem_req drops immediately and the outstanding request is abandoned. Memory must tolerate an abandoned request.
- imem_req and imem_addr are decoded from registered state/PC; they have no combinational path from any input.

## Structure
- Shared package if_pkg: state enum (IDLE, FETCH, DISCARD, HOLD), PC_STEP=4, BUBBLE_INSTR default, ALIGN_MASK=~32'h3.
- One sub-module, if_skid_buffer: one-entry {pc, instr} buffer with load/unload/invalidate/full.
- FSM, PC register and output registers live in the top module.

## Test plan
- Ready tied 1, RESET_PC=0, memory returns data=address: first request at addr 0 one edge after reset release; then pc_out/instr_out = 4/0, 8/4, 12/8 on consecutive cycles with fetch_valid=1.
- Ready 3 cycles after req at 0x10: imem_addr stays 0x10; two bubbles (fetch_valid=0, instr_out=0); then pc_out=0x14.
- freeze=1 on the edge ready completes 0x20: outputs hold and imem_req=0 next cycle. After freeze drops: instr_out=data@0x20, pc_out=0x24, next request at 0x24.
- branch_taken, branch_addr=0x103, while 0x40 is outstanding: imem_addr stays 0x40 until ready; that data is dropped; next request at 0x100; pc_out=0x104. Repeat with branch_taken and freeze both high: branch wins.
- RESET_PC=0xFFFF_FFFC with ready tied 1: pc_out=0x0, next imem_addr=0x0.
- rst asserted mid-DISCARD: imem_req=0 and fetch_valid=0 within the same cycle; restart at RESET_PC after release.
